imu_sample_scheduler: RTL and testbench

IMU_SAMPLE_SCHEDULER -- requirements
Module: imu_sample_scheduler

---
 rtl/imu_sched_pkg.sv | 27 ++
 rtl/imu_period_timer.sv | 29 ++
 rtl/imu_sample_scheduler.sv | 132 +++++++++++++
 tb/tb_imu_sample_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_sched_pkg.sv
// Shared types and helpers for the IMU sample scheduler: FSM state encoding,
// sample width and the saturating subtract used by optional bias removal.
package imu_sched_pkg;

    localparam int IMU_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        START,
        WAIT_DONE
    } state_t;

    // Widen by one bit so the true difference is available, then clamp to the signed range.
    function automatic logic signed [IMU_DW-1:0] sat_sub(
        input logic signed [IMU_DW-1:0] a,
        input logic signed [IMU_DW-1:0] b
    );
        logic signed [IMU_DW:0] diff;
        diff = {a[IMU_DW-1], a} - {b[IMU_DW-1], b};
        if (diff[IMU_DW] != diff[IMU_DW-1])
            sat_sub = diff[IMU_DW] ? {1'b1, {(IMU_DW-1){1'b0}}} : {1'b0, {(IMU_DW-1){1'b1}}};
        else
            sat_sub = diff[IMU_DW-1:0];
    endfunction

endpackage

// File: rtl/imu_period_timer.sv
// Free-running sample period counter: counts 0..PERIOD-1 while run is high,
// emits a one-cycle tick on the last count, and is held at 0 while run is low.
module imu_period_timer #(
    parameter int unsigned PERIOD = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !run)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/imu_sample_scheduler.sv
// Periodic gyro read scheduler with timeout, overrun accounting and a valid/ready
// sample output. Define IMU_BIAS_SUB_EN to add bias_x/y/z ports and saturating bias removal.
module imu_sample_scheduler
    import imu_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD  = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     i2c_start,
    input  logic                     i2c_done,
    input  logic signed [IMU_DW-1:0] i2c_x,
    input  logic signed [IMU_DW-1:0] i2c_y,
    input  logic signed [IMU_DW-1:0] i2c_z,
`ifdef IMU_BIAS_SUB_EN
    input  logic signed [IMU_DW-1:0] bias_x,
    input  logic signed [IMU_DW-1:0] bias_y,
    input  logic signed [IMU_DW-1:0] bias_z,
`endif
    output logic signed [IMU_DW-1:0] out_x,
    output logic signed [IMU_DW-1:0] out_y,
    output logic signed [IMU_DW-1:0] out_z,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic [7:0]               overrun_cnt,
    output logic                     timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                  state, state_next;
    logic                    tick;
    logic [TW-1:0]           tcnt;
    logic                    done_evt, timeout_evt, drop_evt, cap_ovr;
    logic [8:0]              ovr_sum;
    logic signed [IMU_DW-1:0] cap_x, cap_y, cap_z;

    imu_period_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state != IDLE),
        .tick (tick)
    );

    // tcnt is 0 in the first waiting cycle, so the timeout fires in the
    // TIMEOUT_CYCLES-th cycle after the start pulse; a done in that cycle still wins.
    assign done_evt    = (state == WAIT_DONE) && i2c_done;
    assign timeout_evt = (state == WAIT_DONE) && !i2c_done && (tcnt == T_LAST);
    assign drop_evt    = (state == WAIT_DONE) && tick;
    assign cap_ovr     = done_evt && sample_valid && !sample_ready;

`ifdef IMU_BIAS_SUB_EN
    assign cap_x = sat_sub(i2c_x, bias_x);
    assign cap_y = sat_sub(i2c_y, bias_y);
    assign cap_z = sat_sub(i2c_z, bias_z);
`else
    assign cap_x = i2c_x;
    assign cap_y = i2c_y;
    assign cap_z = i2c_z;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (enable) state_next = ARMED;
            ARMED:     if (!enable) state_next = IDLE;
                       else if (tick) state_next = START;
            START:     state_next = WAIT_DONE;
            WAIT_DONE: if (done_evt || timeout_evt) state_next = enable ? ARMED : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        i2c_start = (state == START);
        busy      = (state == WAIT_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if (state == START)
            tcnt <= '0;
        else if (state == WAIT_DONE)
            tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            timeout_err <= 1'b0;
        else if (timeout_evt)
            timeout_err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_x        <= '0;
            out_y        <= '0;
            out_z        <= '0;
            sample_valid <= 1'b0;
        end else if (done_evt) begin
            out_x        <= cap_x;
            out_y        <= cap_y;
            out_z        <= cap_z;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // A dropped tick and an overwritten sample can coincide, so both are summed before clamping.
    assign ovr_sum = {1'b0, overrun_cnt} + {8'd0, drop_evt} + {8'd0, cap_ovr};

    always_ff @(posedge clk) begin
        if (rst)
            overrun_cnt <= '0;
        else
            overrun_cnt <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

endmodule

// File: tb/tb_imu_sample_scheduler.sv
// Directed bench for imu_sample_scheduler with SAMPLE_PERIOD=10, TIMEOUT_CYCLES=20;
// bias cases are exercised when IMU_BIAS_SUB_EN is defined.
module tb_imu_sample_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               i2c_start;
    logic               i2c_done;
    logic signed [15:0] i2c_x, i2c_y, i2c_z;
`ifdef IMU_BIAS_SUB_EN
    logic signed [15:0] bias_x, bias_y, bias_z;
`endif
    logic signed [15:0] out_x, out_y, out_z;
    logic               sample_valid;
    logic               sample_ready;
    logic               busy;
    logic [7:0]         overrun_cnt;
    logic               timeout_err;

    int checks   = 0;
    int failures = 0;

    imu_sample_scheduler #(
        .SAMPLE_PERIOD  (10),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i2c_start    (i2c_start),
        .i2c_done     (i2c_done),
        .i2c_x        (i2c_x),
        .i2c_y        (i2c_y),
        .i2c_z        (i2c_z),
`ifdef IMU_BIAS_SUB_EN
        .bias_x       (bias_x),
        .bias_y       (bias_y),
        .bias_z       (bias_z),
`endif
        .out_x        (out_x),
        .out_y        (out_y),
        .out_z        (out_z),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (i2c_start !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    // Wait for a start pulse, answer dly cycles later with one done pulse.
    task automatic run_txn(input int dly, input logic signed [15:0] x, input logic signed [15:0] y,
                           input logic signed [15:0] z, input logic rdy, output int n);
        wait_start(60, n);
        check("txn_start_seen", 32'(n < 60), 1);
        repeat (dly) step();
        i2c_done     = 1'b1;
        i2c_x        = x;
        i2c_y        = y;
        i2c_z        = z;
        sample_ready = rdy;
        step();
        i2c_done = 1'b0;
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        enable       = 1'b0;
        i2c_done     = 1'b0;
        i2c_x        = '0;
        i2c_y        = '0;
        i2c_z        = '0;
        sample_ready = 1'b0;
`ifdef IMU_BIAS_SUB_EN
        bias_x = '0;
        bias_y = '0;
        bias_z = '0;
`endif
        step();
        step();

        // Reset state
        check("rst_start", i2c_start, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_z", out_z, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_timeout", timeout_err, 0);

        // First transaction: start 11 cycles after enable, done 5 cycles after start
        rst    = 1'b0;
        enable = 1'b1;
        wait_start(60, n);
        check("first_start_lat", n, 11);
        step();
        check("start_one_cycle", i2c_start, 0);
        check("busy_wait", busy, 1);
        repeat (4) step();
        check("pre_capture_valid", sample_valid, 0);
        i2c_done = 1'b1;
        i2c_x    = 100;
        i2c_y    = -200;
        i2c_z    = 300;
        step();
        i2c_done = 1'b0;
        check("cap1_x", out_x, 100);
        check("cap1_y", out_y, -200);
        check("cap1_z", out_z, 300);
        check("cap1_valid", sample_valid, 1);
        check("cap1_busy", busy, 0);

        // Second capture with ready low: overwrite, one overrun; start period is 10
        run_txn(5, -1, 2, -3, 1'b0, n);
        check("period_gap", n, 4);
        check("cap2_x", out_x, -1);
        check("cap2_z", out_z, -3);
        check("cap2_valid", sample_valid, 1);
        check("cap2_overrun", overrun_cnt, 1);
        sample_ready = 1'b1;
        step();
        check("ready_drops_valid", sample_valid, 0);

        // Stray done outside WAIT_DONE is ignored
        i2c_done = 1'b1;
        i2c_x    = 555;
        step();
        i2c_done = 1'b0;
        step();
        check("stray_valid", sample_valid, 0);
        check("stray_out_x", out_x, -1);

        // Capture coinciding with valid&ready: new data, valid stays, no overrun
        run_txn(5, 11, 12, 13, 1'b1, n);
        sample_ready = 1'b0;
        check("cap3_valid", sample_valid, 1);
        check("cap3_x", out_x, 11);
        run_txn(5, 21, 22, 23, 1'b1, n);
        check("cap4_valid", sample_valid, 1);
        check("cap4_y", out_y, 22);
        check("cap4_overrun", overrun_cnt, 1);
        step();
        check("cap4_drop", sample_valid, 0);

        // enable falling mid-transaction does not abort
        sample_ready = 1'b0;
        wait_start(60, n);
        check("en_start_seen", 32'(n < 60), 1);
        step();
        enable = 1'b0;
        repeat (3) step();
        check("en_low_busy", busy, 1);
        i2c_done = 1'b1;
        i2c_x    = 31;
        step();
        i2c_done = 1'b0;
        check("en_low_cap_x", out_x, 31);
        check("en_low_valid", sample_valid, 1);
        check("en_low_idle", busy, 0);
        wait_start(15, n);
        check("en_low_no_start", n, 15);

        // Reset mid-transaction, done on the following cycle is ignored
        enable = 1'b1;
        wait_start(60, n);
        check("rst_txn_start", n, 11);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        i2c_done = 1'b1;
        i2c_x    = 77;
        step();
        i2c_done = 1'b0;
        step();
        check("midrst_valid", sample_valid, 0);
        check("midrst_out_x", out_x, 0);
        check("midrst_busy", busy, 0);
        check("midrst_start", i2c_start, 0);
        check("midrst_overrun", overrun_cnt, 0);
        check("midrst_timeout", timeout_err, 0);

        // Timeout: no done, error set after the 20th waiting cycle; ticks at +9 and +19 dropped
        wait_start(60, n);
        check("to_start_seen", 32'(n < 60), 1);
        repeat (20) step();
        check("to_not_yet", timeout_err, 0);
        check("to_still_busy", busy, 1);
        step();
        check("to_err", timeout_err, 1);
        check("to_busy", busy, 0);
        check("to_valid", sample_valid, 0);
        check("to_overrun", overrun_cnt, 2);
        wait_start(60, n);
        check("to_restart", n, 9);

        // Done and timeout in the same cycle: done wins
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_txn(20, 41, 42, 43, 1'b0, n);
        check("race_err", timeout_err, 0);
        check("race_valid", sample_valid, 1);
        check("race_x", out_x, 41);
        step();
        check("race_err_later", timeout_err, 0);

`ifdef IMU_BIAS_SUB_EN
        bias_x = 100;
        bias_y = -1;
        bias_z = 0;
        run_txn(5, -32700, 32767, 5, 1'b1, n);
        check("bias_sat_lo_x", out_x, -32768);
        check("bias_sat_hi_y", out_y, 32767);
        check("bias_z", out_z, 5);
        bias_x = -50;
        run_txn(5, 500, 0, 0, 1'b1, n);
        check("bias_x_550", out_x, 550);
        bias_x = 0;
        bias_y = 0;
`endif

        // Slow reads: done 15 cycles after start drops one tick each; saturates at 255
        rst          = 1'b1;
        sample_ready = 1'b1;
        step();
        rst = 1'b0;
        run_txn(15, 1, 1, 1, 1'b1, n);
        check("slow_overrun_1", overrun_cnt, 1);
        for (int i = 1; i < 300; i++)
            run_txn(15, 16'(i), 0, 0, 1'b1, n);
        check("slow_overrun_sat", overrun_cnt, 255);
        check("slow_timeout", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
